// File: rtl/ow_txn_arbiter_pkg.sv
// ow_txn_arbiter_pkg: shared 1-Wire arbiter state encoding, ROM commands and defaults
package ow_txn_arbiter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;
  localparam logic [7:0] ROM_READ = 8'h33;
  localparam logic [7:0] ROM_SKIP = 8'hCC;
  localparam logic [7:0] ROM_MATCH = 8'h55;
  localparam int DEF_GAP_CYCLES = 8;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
endpackage

// File: rtl/ow_rr_picker.sv
// ow_rr_picker: first set request bit at or above ptr, wrapping to the lowest set bit
module ow_rr_picker
  import ow_txn_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] lo, hi;
  logic hv;
  always_comb begin
    lo = '0;
    hi = '0;
    hv = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) lo = W'(i);
      if (req[i] && i >= int'(ptr)) begin
        hi = W'(i);
        hv = 1'b1;
      end
    end
  end
  assign idx = hv ? hi : lo;
  assign valid = |req;
endmodule

// File: rtl/ow_txn_arbiter.sv
// ow_txn_arbiter: round-robin sharing of one 1-Wire master engine with timeout and recovery gap
module ow_txn_arbiter
  import ow_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*8-1:0]  req_rom_cmd,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic                  m_start,
  output logic [7:0]            m_rom_cmd,
  output logic [63:0]           m_data,
  output logic                  m_abort,
  input  logic                  m_done,
  input  logic                  m_presence_ok,
  output logic                  busy
);
  localparam int W = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [1:0] state;
  logic [W-1:0] ptr, own, pick;
  logic pick_valid, fin, tmo;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  ow_rr_picker #(.N(NUM_REQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .idx  (pick),
    .valid(pick_valid)
  );
  // m_start is still high in the first BUSY cycle, masking a too-early m_done
  assign fin = m_done && !m_start;
  assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= '0;
      own <= '0;
      tcnt <= '0;
      gcnt <= '0;
      gnt <= '0;
      done <= '0;
      err <= '0;
      m_start <= 1'b0;
      m_abort <= 1'b0;
      busy <= 1'b0;
      m_rom_cmd <= '0;
      m_data <= '0;
    end else begin
      done <= '0;
      err <= '0;
      m_start <= 1'b0;
      m_abort <= 1'b0;
      case (state)
        ST_IDLE: if (pick_valid) begin
          state <= ST_BUSY;
          busy <= 1'b1;
          own <= pick;
          gnt <= NUM_REQ'(1) << pick;
          m_start <= 1'b1;
          m_rom_cmd <= req_rom_cmd[{pick, 3'b0} +: 8];
          m_data <= req_data[{pick, 6'b0} +: 64];
          tcnt <= '0;
        end
        ST_BUSY: if (fin || tmo) begin
          state <= ST_GAP;
          gcnt <= '0;
          done <= gnt;
          err <= (fin && m_presence_ok) ? '0 : gnt;
          m_abort <= !fin;
          gnt <= '0;
          ptr <= (own == W'(NUM_REQ - 1)) ? '0 : own + 1'b1;
        end else tcnt <= tcnt + 1'b1;
        ST_GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end else gcnt <= gcnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ow_txn_arbiter.sv
// tb_ow_txn_arbiter: randomized scenarios against a cycle-level reference model of the arbiter
module tb_ow_txn_arbiter;
  localparam int N = 4, G = 8, T = 16;
  logic clk = 0, reset = 0, m_done = 0, m_presence_ok = 0;
  logic [N-1:0] req = '0;
  logic [N*8-1:0] req_rom_cmd;
  logic [N*64-1:0] req_data;
  logic [N-1:0] gnt, done, err;
  logic m_start, m_abort, busy;
  logic [7:0] m_rom_cmd, ecmd;
  logic [63:0] m_data, edat;
  logic [7:0] cmd[N];
  logic [63:0] dat[N];
  int checks = 0, failures = 0, mptr = 0, cur = 0;
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) begin
    req_rom_cmd[8*i +: 8] = cmd[i];
    req_data[64*i +: 64] = dat[i];
  end
  ow_txn_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rom_cmd(req_rom_cmd), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .m_start(m_start), .m_rom_cmd(m_rom_cmd),
    .m_data(m_data), .m_abort(m_abort), .m_done(m_done), .m_presence_ok(m_presence_ok),
    .busy(busy)
  );
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic check_zero(input string name);
    checks++;
    if ({gnt, done, err, m_start, m_abort, busy, m_rom_cmd, m_data} !== '0) begin
      failures++;
      $display("FAIL %s: gnt=%b done=%b err=%b start=%b abort=%b busy=%b cmd=%h data=%h, required all zero",
               name, gnt, done, err, m_start, m_abort, busy, m_rom_cmd, m_data);
    end
  endtask
  task automatic apply_reset();
    reset = 1; req = '0; m_done = 0;
    tick();
    reset = 0; mptr = 0;
    check_zero("reset_state");
  endtask
  task automatic do_grant();
    int w = pick(req, mptr);
    logic [N-1:0] eg = N'(1) << w;
    ecmd = cmd[w]; edat = dat[w]; cur = w;
    m_done = 1'($urandom);
    tick();
    m_done = 0;
    checks++;
    if ({gnt, done, m_start, busy} !== {eg, N'(0), 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL grant: gnt=%b done=%b start=%b busy=%b required gnt=%b done=0 start=1 busy=1",
               gnt, done, m_start, busy, eg);
    end
    checks++;
    if ({m_rom_cmd, m_data} !== {ecmd, edat}) begin
      failures++;
      $display("FAIL grant_payload: cmd=%h data=%h required cmd=%h data=%h", m_rom_cmd, m_data, ecmd, edat);
    end
  endtask
  // m_done driven d cycles after the start cycle; d=0 lands in the start cycle and is ignored
  task automatic run_busy(input int d, input bit pres, input bit drop);
    bit norm = d >= 1 && d <= T - 1;
    int at = norm ? d + 1 : T;
    logic [N-1:0] eg = N'(1) << cur;
    logic [N-1:0] eerr = (norm && pres) ? N'(0) : eg;
    for (int k = 0; k < at; k++) begin
      m_done = (k == d);
      m_presence_ok = (k == d) ? pres : 1'($urandom);
      if (k == 1) begin
        cmd[cur] = 8'($urandom);
        dat[cur] = {$urandom, $urandom};
        if (drop) req[cur] = 1'b0;
      end
      tick();
      m_done = 0;
      if (k + 1 < at) begin
        checks++;
        if ({gnt, done, err, m_start, m_abort, busy} !== {eg, N'(0), N'(0), 3'b001}) begin
          failures++;
          $display("FAIL busy_hold k=%0d: gnt=%b done=%b err=%b start=%b abort=%b busy=%b required gnt=%b start=0 busy=1",
                   k, gnt, done, err, m_start, m_abort, busy, eg);
        end
        checks++;
        if ({m_rom_cmd, m_data} !== {ecmd, edat}) begin
          failures++;
          $display("FAIL payload_stable: cmd=%h data=%h required cmd=%h data=%h", m_rom_cmd, m_data, ecmd, edat);
        end
      end
    end
    checks++;
    if ({gnt, done, err, m_abort, busy} !== {N'(0), eg, eerr, !norm, 1'b1}) begin
      failures++;
      $display("FAIL completion d=%0d: gnt=%b done=%b err=%b abort=%b busy=%b required gnt=0 done=%b err=%b abort=%b busy=1",
               d, gnt, done, err, m_abort, busy, eg, eerr, !norm);
    end
    mptr = (cur + 1) % N;
  endtask
  task automatic run_gap(input bit keep);
    if (!keep) req[cur] = 1'b0;
    for (int g = 1; g <= G; g++) begin
      m_done = 1'($urandom);
      m_presence_ok = 1'($urandom);
      tick();
      checks++;
      if ({gnt, done, err, m_start, m_abort, busy} !== {N'(0), N'(0), N'(0), 2'b00, g < G}) begin
        failures++;
        $display("FAIL gap g=%0d: gnt=%b done=%b err=%b start=%b abort=%b busy=%b required all zero busy=%b",
                 g, gnt, done, err, m_start, m_abort, busy, g < G);
      end
    end
    m_done = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_zero("reset_initial");
    for (int i = 0; i < N; i++) begin cmd[i] = ROMS(i); dat[i] = {$urandom, $urandom}; end
  endtask
  function automatic logic [7:0] ROMS(int i);
    logic [7:0] t[3] = '{8'h33, 8'hCC, 8'h55};
    return t[i % 3];
  endfunction
  task automatic test_single();
    apply_reset();
    cmd[1] = 8'h33; dat[1] = 64'hDEAD_BEEF_0123_4567; req = 4'b0010;
    do_grant();
    run_busy(3, 1, 0);
    run_gap(0);
  endtask
  task automatic test_round_robin();
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_grant();
      run_busy($urandom_range(1, 10), 1, 0);
      run_gap(1);
    end
    apply_reset();
  endtask
  task automatic test_no_presence();
    req = 4'b1000;
    do_grant();
    run_busy($urandom_range(1, 14), 0, 0);
    run_gap(0);
  endtask
  task automatic test_timeout();
    req = 4'b0101;
    do_grant();
    run_busy(-1, 1, 0);
    run_gap(0);
  endtask
  task automatic test_collision();
    req = 4'b0110;
    do_grant(); run_busy(T - 1, 1, 0); run_gap(1);
    do_grant(); run_busy(T - 1, 0, 0); run_gap(0);
    req = 4'b0001;
    do_grant(); run_busy(0, 1, 0); run_gap(0);
  endtask
  task automatic test_req_drop();
    req = 4'b0100;
    do_grant();
    run_busy(6, 1, 1);
    run_gap(0);
  endtask
  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0010;
    do_grant(); run_busy(2, 1, 0); run_gap(0);
    req = 4'b0110;
    do_grant();
    for (int i = 0; i < 3; i++) tick();
    reset = 1; req = 4'b0101;
    tick();
    reset = 0; mptr = 0;
    check_zero("reset_mid_busy");
    do_grant();
    run_busy(4, 1, 0);
    run_gap(0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      bit keep;
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      do_grant();
      run_busy($urandom_range(0, T + 1), 1'($urandom), $urandom_range(0, 3) == 0);
      keep = 1'($urandom);
      run_gap(keep);
      if (!keep) req |= N'($urandom);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_presence();
    test_timeout();
    test_collision();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ow_txn_arbiter.md
Name: ow_txn_arbiter

Overview:
- Shares one 1-Wire master transaction engine among NUM_REQ requesters.
- Each requester posts a complete transaction: ROM command byte plus 64-bit data word.
- The arbiter grants one requester round-robin, latches its command and data, pulses start to the master engine, and waits for completion or timeout.
- It reports a per-requester done/error, then enforces a bus recovery gap before the next grant.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 8, idle clk cycles between end of one transaction and next grant (>=1)
TIMEOUT_CYCLES, 4096, max clk cycles in BUSY before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
req  in  NUM_REQ  per-requester transaction request, level, held until done
req_rom_cmd  in  NUM_REQ*8  flat ROM command bytes, requester i at [8i+7:8i]
req_data  in  NUM_REQ*64  flat data words, requester i at [64i+63:64i]
gnt  out  NUM_REQ  one-hot grant, high for whole transaction
done  out  NUM_REQ  one-cycle completion pulse to owning requester
err  out  NUM_REQ  qualifies done: 1 = no presence or timeout
m_start  out  1  one-cycle start pulse to master engine
m_rom_cmd  out  8  latched ROM command, stable while gnt nonzero
m_data  out  64  latched data, stable while gnt nonzero
m_abort  out  1  one-cycle abort pulse to master engine on timeout
m_done  in  1  master engine completion pulse
m_presence_ok  in  1  presence result, valid with m_done
busy  out  1  high in BUSY and GAP

Behaviour:
- Reset values:
  - gnt, done, err, m_start, m_abort, busy, m_rom_cmd, m_data = 0
  - state = IDLE; rr pointer = 0; timeout and gap counters = 0
- Reset mid-operation returns to IDLE in one cycle. No done or m_abort is issued for the killed transaction.
- States: IDLE, BUSY, GAP. Registered outputs only.
- IDLE:
  - If req != 0, select the first set bit searching from rr pointer upward with wrap.
  - Next cycle: gnt[w]=1, m_start=1 (single cycle), m_rom_cmd/m_data latched from slice w, timeout counter cleared, state=BUSY.
  - Latency is exactly 1 cycle from req sampled to gnt/m_start.
- BUSY:
  - m_done is ignored in the m_start cycle and sampled from the following cycle.
  - On m_done: next cycle done[w]=1, err[w]=~m_presence_ok, gnt=0, rr pointer=(w+1) mod NUM_REQ, state=GAP.
  - Timeout counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES-1 without m_done: next cycle done[w]=1, err[w]=1, m_abort=1, gnt=0, rr advances, state=GAP.
  - m_done and timeout expiry in the same cycle: m_done wins, with no m_abort and err from presence.
  - req[w] dropping during BUSY is ignored. The transaction completes and done is still pulsed.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE. No grant is issued during GAP.
  - req is not sampled in GAP; arbitration happens in the first IDLE cycle.
- m_done outside BUSY is ignored.
- done/err pulse for exactly one cycle and are zero in all other bits and cycles.
- Requesters must deassert req in the cycle after done; req still high in IDLE re-requests normally.
- Timeout counter width = clog2(TIMEOUT_CYCLES); gap counter width = clog2(GAP_CYCLES+1). No overflow possible.

Decomposition:
- Shared 1-Wire package holds:
  - State encoding (IDLE/BUSY/GAP).
  - ROM command constants: READ 8'h33, SKIP 8'hCC, MATCH 8'h55.
  - Default GAP/TIMEOUT values.
- One sub-module: ow_rr_picker, combinational round-robin first-set-bit search from pointer with wrap, returning index and valid.

Test Plan:
- Single request: req=4'b0010, cmd 8'h33, data 64'hDEAD_BEEF_0123_4567 -> gnt=4'b0010 and m_start 1 cycle later, m_rom_cmd=8'h33, m_data matches; m_done with presence=1 -> done[1]=1, err[1]=0 next cycle; no grant for 8 cycles.
- Round robin: req=4'b1111 held, each transaction completed -> grant order 0,1,2,3,0 with gap of 8 cycles between each.
- No presence: m_done with m_presence_ok=0 -> done[w]=1, err[w]=1, m_abort=0.
- Timeout: TIMEOUT_CYCLES=16, never assert m_done -> after 16 BUSY cycles, m_abort=1, done[w]=1, err[w]=1, gnt=0.
- Collision: m_done on the final timeout cycle -> err follows presence, m_abort stays 0. m_done in the m_start cycle -> ignored, still BUSY.
- Reset mid-BUSY: assert reset for 1 cycle -> all outputs 0 next cycle, no done; req=4'b0100 afterwards -> gnt=4'b0100 (pointer reset to 0).
